// File: rtl/audio_out.sv
// I2S master transmitter: one 16-bit stereo pair per 64-BCLK-half frame, MSB first, one-bit delay.
// A pair held before the load slot is sent at that slot; upstream stalls on in_ready while the hold is full.
module audio_out #(
   parameter int BCLK_DIV = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] in_left,
   input  logic [15:0] in_right,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        BCLK,
   output logic        LRCLK,
   output logic        DACDAT,
   output logic        frame_start,
   output logic        underrun
);

   localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

   logic [DW-1:0] div_cnt;
   logic [4:0]    bit_cnt;
   logic [4:0]    bit_nxt;
   logic [31:0]   sr;
   logic [15:0]   hold_left;
   logic [15:0]   hold_right;
   logic          hold_full;
   logic          tc;
   logic          fall;
   logic          load;
   logic          accept;

   always_comb begin
      tc          = (div_cnt == DW'(BCLK_DIV - 1));
      fall        = tc && BCLK;
      load        = fall && (bit_cnt == 5'd0);
      bit_nxt     = bit_cnt + 5'd1;
      in_ready    = !rst && !hold_full;
      accept      = in_valid && in_ready;
      frame_start = !rst && fall && (bit_cnt == 5'd31);
      underrun    = !rst && load && !hold_full;
   end

   assign DACDAT = sr[31];

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt    <= '0;
         BCLK       <= 1'b0;
         bit_cnt    <= 5'd31;
         LRCLK      <= 1'b1;
         sr         <= '0;
         hold_left  <= '0;
         hold_right <= '0;
         hold_full  <= 1'b0;
      end else begin
         if (tc) begin
            div_cnt <= '0;
            BCLK    <= ~BCLK;
         end else begin
            div_cnt <= div_cnt + DW'(1);
         end

         if (fall) begin
            bit_cnt <= bit_nxt;
            LRCLK   <= bit_nxt[4];
            // An empty hold replays the last pair rather than going silent.
            if (load)
               sr <= {hold_left, hold_right};
            else
               sr <= {sr[30:0], 1'b0};
         end

         // The load above always reads the pre-edge hold, so a same-cycle accept waits a frame.
         if (accept) begin
            hold_left  <= in_left;
            hold_right <= in_right;
            hold_full  <= 1'b1;
         end else if (load) begin
            hold_full  <= 1'b0;
         end
      end
   end

endmodule
